// File: rtl/de_pipe_reg.sv
// D->E pipeline register for the P7 MIPS core, in front of the mult/div unit.
// Latency: D->E 1 cycle; stall_out is combinational (0 cycles).
// Backpressure: stall_out freezes PC and F/D; E gets a bubble, while a Req flush overrides the stall.
// Optional feature: define MD_STALL_CNT_EN to build the saturating mult/div stall counter.
module de_pipe_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        hz_stall_in,
  input  logic        md_busy,
  input  logic [31:0] D_instr,
  input  logic [31:0] D_pc,
  input  logic [31:0] D_rs_data,
  input  logic [31:0] D_rt_data,
  input  logic [31:0] D_ext,
  input  logic [4:0]  D_exccode,
  input  logic        D_bd,
  output logic [31:0] E_instr,
  output logic [31:0] E_pc,
  output logic [31:0] E_rs_data,
  output logic [31:0] E_rt_data,
  output logic [31:0] E_ext,
  output logic [4:0]  E_exccode,
  output logic        E_bd,
  output logic        stall_out,
  output logic [31:0] md_stall_cnt
);

  logic [31:0] r_e_instr;
  logic [31:0] r_e_pc;
  logic [31:0] r_e_rs_data;
  logic [31:0] r_e_rt_data;
  logic [31:0] r_e_ext;
  logic [4:0]  r_e_exccode;
  logic        r_e_bd;

  logic        w_d_is_md;
  logic        w_e_start;
  logic        w_md_stall;
  logic        w_stall;

  // Decode D: any instruction that touches the mult/div unit (starts or HI/LO moves).
  always_comb begin
    w_d_is_md = 1'b0;
    if (D_instr[31:26] == 6'h00) begin
      case (D_instr[5:0])
        6'h18, 6'h19, 6'h1A, 6'h1B,
        6'h10, 6'h11, 6'h12, 6'h13: w_d_is_md = 1'b1;
        default:                    w_d_is_md = 1'b0;
      endcase
    end
  end

  // Decode E: an instruction that will start the mult/div unit next cycle.
  // A bubble (all-zero sll) has funct 0 and so never counts as a start.
  always_comb begin
    w_e_start = 1'b0;
    if (r_e_instr[31:26] == 6'h00) begin
      case (r_e_instr[5:0])
        6'h18, 6'h19, 6'h1A, 6'h1B: w_e_start = 1'b1;
        default:                    w_e_start = 1'b0;
      endcase
    end
  end

  assign w_md_stall = w_d_is_md && (w_e_start || md_busy);
  // A flush discards D anyway, so holding it would only delay the handler.
  assign w_stall    = (w_md_stall || hz_stall_in) && !Req;
  assign stall_out  = w_stall;

  // E register update: reset > flush > bubble > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_instr   <= 32'h0;
      r_e_pc      <= RESET_PC;
      r_e_rs_data <= 32'h0;
      r_e_rt_data <= 32'h0;
      r_e_ext     <= 32'h0;
      r_e_exccode <= 5'h0;
      r_e_bd      <= 1'b0;
    end else if (Req) begin
      r_e_instr   <= 32'h0;
      r_e_pc      <= HANDLER_PC;
      r_e_rs_data <= 32'h0;
      r_e_rt_data <= 32'h0;
      r_e_ext     <= 32'h0;
      r_e_exccode <= 5'h0;
      r_e_bd      <= 1'b0;
    end else if (w_stall) begin
      // Bubble keeps PC/BD of the held D instruction so EPC stays correct
      // if an interrupt lands on the bubble; the exception code stays in D.
      r_e_instr   <= 32'h0;
      r_e_pc      <= D_pc;
      r_e_rs_data <= 32'h0;
      r_e_rt_data <= 32'h0;
      r_e_ext     <= 32'h0;
      r_e_exccode <= 5'h0;
      r_e_bd      <= D_bd;
    end else begin
      r_e_instr   <= D_instr;
      r_e_pc      <= D_pc;
      r_e_rs_data <= D_rs_data;
      r_e_rt_data <= D_rt_data;
      r_e_ext     <= D_ext;
      r_e_exccode <= D_exccode;
      r_e_bd      <= D_bd;
    end
  end

  assign E_instr   = r_e_instr;
  assign E_pc      = r_e_pc;
  assign E_rs_data = r_e_rs_data;
  assign E_rt_data = r_e_rt_data;
  assign E_ext     = r_e_ext;
  assign E_exccode = r_e_exccode;
  assign E_bd      = r_e_bd;

`ifdef MD_STALL_CNT_EN
  logic [31:0] r_md_stall_cnt;

  // Count cycles lost to mult/div stalls; flushed cycles are not lost to md.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_stall_cnt <= 32'h0;
    end else if (w_md_stall && !Req && (r_md_stall_cnt != 32'hFFFF_FFFF)) begin
      r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
    end
  end

  assign md_stall_cnt = r_md_stall_cnt;
`else
  assign md_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed bench for de_pipe_reg: vector table plus counter corner sequences.
// Inputs driven on negedge; stall_out sampled mid-low phase, E_* sampled #1 after posedge.
// Summary line reports vectors-compared and failures.
module tb_de_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, Req, hz_stall_in, md_busy, D_bd, E_bd, stall_out;
  logic [31:0] D_instr, D_pc, D_rs_data, D_rt_data, D_ext;
  logic [4:0]  D_exccode, E_exccode;
  logic [31:0] E_instr, E_pc, E_rs_data, E_rt_data, E_ext, md_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  de_pipe_reg dut (
    .clk(clk), .reset(reset), .Req(Req), .hz_stall_in(hz_stall_in), .md_busy(md_busy),
    .D_instr(D_instr), .D_pc(D_pc), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
    .D_ext(D_ext), .D_exccode(D_exccode), .D_bd(D_bd),
    .E_instr(E_instr), .E_pc(E_pc), .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
    .E_ext(E_ext), .E_exccode(E_exccode), .E_bd(E_bd),
    .stall_out(stall_out), .md_stall_cnt(md_stall_cnt)
  );

  localparam logic [31:0] ADDU  = 32'h0022_1821;
  localparam logic [31:0] ADDIU = 32'h2400_0018; // funct field 0x18 but not SPECIAL
  localparam logic [31:0] MULT  = 32'h0000_0018;
  localparam logic [31:0] MULTU = 32'h0000_0019;
  localparam logic [31:0] DIV   = 32'h0000_001A;
  localparam logic [31:0] DIVU  = 32'h0000_001B;
  localparam logic [31:0] MFHI  = 32'h0000_0010;
  localparam logic [31:0] MTHI  = 32'h0000_0011;
  localparam logic [31:0] MFLO  = 32'h0000_0012;
  localparam logic [31:0] MTLO  = 32'h0000_0013;

  typedef struct {
    logic        rst, req, hz, busy;
    logic [31:0] instr, pc, rs, rt, ext;
    logic [4:0]  exc;
    logic        bd;
    logic        x_stall; // expected stall_out
    logic        x_cnt;   // expected counter increment this edge
    logic [31:0] x_instr, x_pc, x_rs, x_rt, x_ext;
    logic [4:0]  x_exc;
    logic        x_bd;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(
    logic rst, logic req, logic hz, logic busy,
    logic [31:0] instr, logic [31:0] pc, logic [31:0] rs, logic [31:0] rt, logic [31:0] ext,
    logic [4:0] exc, logic bd, logic x_stall, logic x_cnt,
    logic [31:0] x_instr, logic [31:0] x_pc, logic [31:0] x_rs, logic [31:0] x_rt,
    logic [31:0] x_ext, logic [4:0] x_exc, logic x_bd);
    vec_t v;
    v.rst = rst; v.req = req; v.hz = hz; v.busy = busy;
    v.instr = instr; v.pc = pc; v.rs = rs; v.rt = rt; v.ext = ext; v.exc = exc; v.bd = bd;
    v.x_stall = x_stall; v.x_cnt = x_cnt;
    v.x_instr = x_instr; v.x_pc = x_pc; v.x_rs = x_rs; v.x_rt = x_rt; v.x_ext = x_ext;
    v.x_exc = x_exc; v.x_bd = x_bd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; Req = v.req; hz_stall_in = v.hz; md_busy = v.busy;
    D_instr = v.instr; D_pc = v.pc; D_rs_data = v.rs; D_rt_data = v.rt;
    D_ext = v.ext; D_exccode = v.exc; D_bd = v.bd;
  endtask

  logic [31:0] exp_cnt;

  initial begin
    vec_t v;
    //                rst req hz bsy instr  pc            rs     rt     ext    exc bd  stl cnt  E: instr  pc            rs     rt     ext    exc bd
    vecs[0]  = mk(1, 0, 0, 0, ADDU,  32'h3000, 32'h01, 32'h02, 32'h03, 0, 0,  0, 0,  0,     32'h3000, 0,      0,      0,      0, 0);
    vecs[1]  = mk(0, 0, 0, 0, MULT,  32'h3000, 32'h11, 32'h22, 32'h33, 0, 0,  0, 0,  MULT,  32'h3000, 32'h11, 32'h22, 32'h33, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, MFLO,  32'h3004, 32'h44, 32'h55, 32'h66, 0, 0,  1, 1,  0,     32'h3004, 0,      0,      0,      0, 0);
    vecs[3]  = mk(0, 0, 0, 0, MFLO,  32'h3004, 32'h44, 32'h55, 32'h66, 0, 0,  0, 0,  MFLO,  32'h3004, 32'h44, 32'h55, 32'h66, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, ADDIU, 32'h3008, 32'hA1, 32'hA2, 32'hA3, 0, 0,  0, 0,  ADDIU, 32'h3008, 32'hA1, 32'hA2, 32'hA3, 0, 0);
    for (int i = 5; i <= 9; i++)
      vecs[i] = mk(0, 0, 0, 1, MFHI, 32'h300C, 32'hB1, 32'hB2, 32'hB3, 3, 1,  1, 1,  0,     32'h300C, 0,      0,      0,      0, 1);
    vecs[10] = mk(0, 0, 0, 0, MFHI,  32'h300C, 32'hB1, 32'hB2, 32'hB3, 3, 1,  0, 0,  MFHI,  32'h300C, 32'hB1, 32'hB2, 32'hB3, 3, 1);
    vecs[11] = mk(0, 1, 0, 1, DIV,   32'h3010, 32'hC1, 32'hC2, 32'hC3, 5, 1,  0, 0,  0,     32'h4180, 0,      0,      0,      0, 0);
    vecs[12] = mk(0, 0, 1, 0, ADDU,  32'h3010, 32'hD1, 32'hD2, 32'hD3, 7, 1,  1, 0,  0,     32'h3010, 0,      0,      0,      0, 1);
    vecs[13] = mk(0, 1, 1, 0, ADDU,  32'h3010, 32'hD1, 32'hD2, 32'hD3, 7, 1,  0, 0,  0,     32'h4180, 0,      0,      0,      0, 0);
    vecs[14] = mk(0, 0, 0, 0, ADDU,  32'h3014, 32'hD1, 32'hD2, 32'hD3, 7, 1,  0, 0,  ADDU,  32'h3014, 32'hD1, 32'hD2, 32'hD3, 7, 1);
    vecs[15] = mk(0, 0, 0, 0, MULT,  32'h3018, 32'hE1, 32'hE2, 32'hE3, 0, 0,  0, 0,  MULT,  32'h3018, 32'hE1, 32'hE2, 32'hE3, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, DIVU,  32'h301C, 32'hF1, 32'hF2, 32'hF3, 0, 0,  1, 1,  0,     32'h301C, 0,      0,      0,      0, 0);
    vecs[17] = mk(0, 0, 0, 0, DIVU,  32'h301C, 32'hF1, 32'hF2, 32'hF3, 0, 0,  0, 0,  DIVU,  32'h301C, 32'hF1, 32'hF2, 32'hF3, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, MTLO,  32'h3020, 32'h111, 32'h112, 32'h113, 0, 0, 1, 1, 0,     32'h3020, 0,      0,      0,      0, 0);
    vecs[19] = mk(0, 0, 0, 0, MTLO,  32'h3020, 32'h111, 32'h112, 32'h113, 0, 0, 0, 0, MTLO,  32'h3020, 32'h111, 32'h112, 32'h113, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, MULTU, 32'h3024, 32'h121, 32'h122, 32'h123, 0, 0, 0, 0, MULTU, 32'h3024, 32'h121, 32'h122, 32'h123, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, MTHI,  32'h3028, 32'h131, 32'h132, 32'h133, 0, 0, 1, 0, 0,     32'h3000, 0,      0,      0,      0, 0);
    vecs[22] = mk(0, 0, 0, 0, MTHI,  32'h3028, 32'h131, 32'h132, 32'h133, 0, 0, 0, 0, MTHI,  32'h3028, 32'h131, 32'h132, 32'h133, 0, 0);

    drive(vecs[0]);
    exp_cnt = 32'h0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v);
      #1;
      check($sformatf("v%0d stall_out", i), {31'h0, stall_out}, {31'h0, v.x_stall});
      @(posedge clk);
      #1;
      if (v.rst) exp_cnt = 32'h0;
      else if (v.x_cnt && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      check($sformatf("v%0d E_instr", i),   E_instr,   v.x_instr);
      check($sformatf("v%0d E_pc", i),      E_pc,      v.x_pc);
      check($sformatf("v%0d E_rs_data", i), E_rs_data, v.x_rs);
      check($sformatf("v%0d E_rt_data", i), E_rt_data, v.x_rt);
      check($sformatf("v%0d E_ext", i),     E_ext,     v.x_ext);
      check($sformatf("v%0d E_exccode", i), {27'h0, E_exccode}, {27'h0, v.x_exc});
      check($sformatf("v%0d E_bd", i),      {31'h0, E_bd},      {31'h0, v.x_bd});
`ifdef MD_STALL_CNT_EN
      check($sformatf("v%0d md_stall_cnt", i), md_stall_cnt, exp_cnt);
`else
      check($sformatf("v%0d md_stall_cnt tied", i), md_stall_cnt, 32'h0);
`endif
    end

    // Counter saturation: three md stalls from a preloaded near-max count,
    // then a flushed md-stall cycle that must not touch the counter.
    @(negedge clk);
    reset = 1'b0; Req = 1'b0; hz_stall_in = 1'b0; md_busy = 1'b1;
    D_instr = MFLO; D_pc = 32'h3030; D_exccode = 5'h0; D_bd = 1'b0;
`ifdef MD_STALL_CNT_EN
    force dut.r_md_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_md_stall_cnt;
    exp_cnt = 32'hFFFF_FFFE;
`else
    exp_cnt = 32'h0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        @(negedge clk);
        Req = 1'b1;
      end
      @(posedge clk);
      #1;
`ifdef MD_STALL_CNT_EN
      if (k == 0) exp_cnt = 32'hFFFF_FFFF;
`endif
      check($sformatf("sat%0d md_stall_cnt", k), md_stall_cnt, exp_cnt);
      check($sformatf("sat%0d E_instr", k), E_instr, 32'h0);
    end
    check("sat flush E_pc", E_pc, 32'h0000_4180);

    @(negedge clk);
    Req = 1'b0; md_busy = 1'b0;
    @(posedge clk);
    #1;
    check("post-busy load E_instr", E_instr, MFLO);
    check("post-busy load E_pc", E_pc, 32'h3030);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
